// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings, FSM states and flag bit indices for alu_seq.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_NOT = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int F_C = 3;
    localparam int F_V = 2;
    localparam int F_N = 1;
    localparam int F_Z = 0;

    function automatic logic is_iter(input op_e op);
        return op == OP_SHL || op == OP_MUL;
    endfunction

endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle W-bit ops with carry/overflow; SHL and MUL are handled iteratively by alu_seq.
module alu_comb
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  op_e          op,
    output logic [W-1:0] res,
    output logic         c,
    output logic         v
);

    logic [W:0] add_r;
    logic [W:0] sub_r;

    assign add_r = {1'b0, a} + {1'b0, b};
    // Subtraction as A + ~B + 1 so carry out means no borrow
    assign sub_r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        unique case (op)
            OP_ADD: begin
                res = add_r[W-1:0];
                c   = add_r[W];
                v   = (a[W-1] == b[W-1]) && (add_r[W-1] != a[W-1]);
            end
            OP_SUB: begin
                res = sub_r[W-1:0];
                c   = sub_r[W];
                v   = (a[W-1] != b[W-1]) && (sub_r[W-1] != a[W-1]);
            end
            OP_AND:  res = a & b;
            OP_NOT:  res = ~b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; single-cycle ops via alu_comb, SHL one bit per cycle,
// MUL as W-step unsigned shift-add; result and flags registered until consumed.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W  = 16,
    parameter int SW = $clog2(W)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] Ain,
    input  logic [W-1:0] Bin,
    input  logic [2:0]   ALUop,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic [3:0]   flags
);

    state_e         state, state_nx;
    op_e            op_in, op_q;
    logic           fire, last, is_mul;
    logic [W-1:0]   hi, lo, bq;
    logic [SW:0]    cnt;
    logic [W-1:0]   c_res;
    logic           c_c, c_v;
    logic [W:0]     sum;
    logic [W-1:0]   hi_mul, lo_mul, lo_sh;
    logic           sh_c;
    logic [W-1:0]   res_nx;
    logic           c_nx, v_nx;
    logic [3:0]     flags_nx;

    assign op_in     = op_e'(ALUop);
    assign in_ready  = state == S_IDLE;
    assign out_valid = state == S_DONE;
    assign fire      = in_valid && in_ready;
    assign is_mul    = op_q == OP_MUL;
    assign last      = cnt <= (SW+1)'(1);

    alu_comb #(.W(W)) u_comb (
        .a   (Ain),
        .b   (Bin),
        .op  (op_in),
        .res (c_res),
        .c   (c_c),
        .v   (c_v)
    );

    // {hi,lo} holds the running partial product; lo's LSB selects whether B is added
    assign sum    = {1'b0, hi} + (lo[0] ? {1'b0, bq} : '0);
    assign hi_mul = sum[W:1];
    assign lo_mul = {sum[0], lo[W-1:1]};
    assign lo_sh  = (cnt != '0) ? lo << 1 : lo;
    assign sh_c   = (cnt != '0) && lo[W-1];

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (fire) state_nx = is_iter(op_in) ? S_BUSY : S_DONE;
            S_BUSY:  if (last) state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        res_nx = (state == S_IDLE) ? c_res : is_mul ? lo_mul : lo_sh;
        c_nx   = (state == S_IDLE) ? c_c : !is_mul && sh_c;
        v_nx   = (state == S_IDLE) ? c_v : is_mul && (hi_mul != '0);
        flags_nx      = '0;
        flags_nx[F_C] = c_nx;
        flags_nx[F_V] = v_nx;
        flags_nx[F_N] = res_nx[W-1];
        flags_nx[F_Z] = res_nx == '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q  <= OP_ADD;
            hi    <= '0;
            lo    <= '0;
            bq    <= '0;
            cnt   <= '0;
            out   <= '0;
            flags <= '0;
        end else begin
            if (fire) begin
                op_q <= op_in;
                bq   <= Bin;
                hi   <= '0;
                lo   <= Ain;
                cnt  <= (op_in == OP_MUL) ? (SW+1)'(W) : {1'b0, Bin[SW-1:0]};
            end else if (state == S_BUSY) begin
                hi  <= is_mul ? hi_mul : hi;
                lo  <= is_mul ? lo_mul : lo_sh;
                cnt <= (cnt != '0) ? cnt - (SW+1)'(1) : cnt;
            end
            if (state_nx == S_DONE && state != S_DONE) begin
                out   <= res_nx;
                flags <= flags_nx;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven directed checks of alu_seq (W=16) plus handshake, hold and reset sequences.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] Ain, Bin;
    logic [2:0]  ALUop;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic [3:0]  flags;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    vec_t vt[17];

    alu_seq #(.W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Ain       (Ain),
        .Bin       (Bin),
        .ALUop     (ALUop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Handshake one op, scramble inputs afterwards, wait (bounded) for out_valid
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output int ir);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; ALUop = op; Ain = a; Bin = b;
        @(negedge clk);
        in_valid = 1'b0; ALUop = ~op; Ain = ~a; Bin = ~b;
        lat = 1;
        ir  = 0;
        while (!out_valid && lat < 64) begin
            ir += int'(in_ready);
            @(negedge clk);
            lat++;
        end
        ir += int'(in_ready);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("consume_valid", out_valid, 0);
        chk("consume_ready", in_ready, 1);
    endtask

    initial begin
        int lat, ir;
        vt[0]  = '{3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0110, 1};
        vt[1]  = '{3'b001, 16'h0005, 16'h0005, 16'h0000, 4'b1001, 1};
        vt[2]  = '{3'b001, 16'h0000, 16'h0001, 16'hFFFF, 4'b0010, 1};
        vt[3]  = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b1001, 1};
        vt[4]  = '{3'b010, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000, 1};
        vt[5]  = '{3'b011, 16'h1234, 16'h00FF, 16'hFF00, 4'b0010, 1};
        vt[6]  = '{3'b100, 16'h8000, 16'h0001, 16'h8001, 4'b0010, 1};
        vt[7]  = '{3'b101, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0001, 1};
        vt[8]  = '{3'b110, 16'h8001, 16'h0001, 16'h0002, 4'b1000, 2};
        vt[9]  = '{3'b110, 16'h8001, 16'h0000, 16'h8001, 4'b0010, 2};
        vt[10] = '{3'b110, 16'h0003, 16'hFFF4, 16'h0030, 4'b0000, 5};
        vt[11] = '{3'b110, 16'h0001, 16'h000F, 16'h8000, 4'b0010, 16};
        vt[12] = '{3'b110, 16'hC000, 16'h0002, 16'h0000, 4'b1001, 3};
        vt[13] = '{3'b111, 16'h0100, 16'h0100, 16'h0000, 4'b0101, 17};
        vt[14] = '{3'b111, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 17};
        vt[15] = '{3'b111, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0100, 17};
        vt[16] = '{3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'b1100, 1};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        Ain = '0; Bin = '0; ALUop = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_out", out, 0);
        chk("rst_flags", flags, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);

        for (int i = 0; i < 17; i++) begin
            issue(vt[i].op, vt[i].a, vt[i].b, lat, ir);
            chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("v%0d_out", i), out, vt[i].res);
            chk($sformatf("v%0d_flags", i), flags, vt[i].fl);
            chk($sformatf("v%0d_busy_ready", i), ir, 0);
            consume();
        end

        // Result held while consumer stalls; new requests ignored meanwhile
        issue(3'b000, 16'h1234, 16'h1111, lat, ir);
        chk("hold_lat", lat, 1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; ALUop = 3'b000; Ain = 16'hFFFF; Bin = 16'hFFFF;
            @(negedge clk);
            chk($sformatf("hold%0d_out", k), out, 16'h2345);
            chk($sformatf("hold%0d_flags", k), flags, 4'b0000);
            chk($sformatf("hold%0d_valid", k), out_valid, 1);
            chk($sformatf("hold%0d_ready", k), in_ready, 0);
        end
        in_valid = 1'b0;
        consume();
        chk("hold_after_out", out, 16'h2345);

        // Reset on the 4th BUSY cycle of a MUL aborts it
        @(negedge clk);
        in_valid = 1'b1; ALUop = 3'b111; Ain = 16'h0100; Bin = 16'h0100;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy", in_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_out", out, 0);
        chk("abort_flags", flags, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_ready", in_ready, 1);
        repeat (20) @(negedge clk);
        chk("abort_no_result", out_valid, 0);
        issue(3'b000, 16'h0001, 16'h0001, lat, ir);
        chk("post_abort_lat", lat, 1);
        chk("post_abort_out", out, 16'h0002);
        chk("post_abort_flags", flags, 4'b0000);
        consume();

        // Reset beats a simultaneous handshake
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; ALUop = 3'b111; Ain = 16'h0003; Bin = 16'h0003;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        chk("rst_prio_ready", in_ready, 1);
        chk("rst_prio_valid", out_valid, 0);
        @(negedge clk);
        chk("rst_prio_idle", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
